// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the Montgomery reduction block.
package mont_pkg;

  localparam int unsigned WIDTH     = 256;
  localparam int unsigned CNT_W     = 9;
  localparam int unsigned LAST_ITER = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    CORR = 2'd2
  } mont_state_e;

endpackage

// File: rtl/mont_reduce_if.sv
// Request/result bundle between a requester (master) and mont_reduce (slave).
interface mont_reduce_if;
  import mont_pkg::*;

  logic             start;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] m;
  logic             finish;
  logic             busy;
  logic             err;

  modport master (
    output start, N, a,
    input  m, finish, busy, err
  );

  modport slave (
    input  start, N, a,
    output m, finish, busy, err
  );

endinterface

// File: rtl/mont_halve_step.sv
// One bit-serial Montgomery step: make t even by adding N when odd, then halve.
module mont_halve_step
  import mont_pkg::*;
(
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] t_next
);

  logic [WIDTH:0] sum;

  // Single 257-bit adder; the carry lands in the top bit and survives the shift.
  always_comb begin
    sum    = {1'b0, t} + (t[0] ? {1'b0, N} : {(WIDTH + 1){1'b0}});
    t_next = WIDTH'(sum >> 1);
  end

endmodule

// File: rtl/mont_reduce.sv
// Montgomery reduction m = a * 2^-256 mod N, one bit per cycle plus a final
// conditional subtract. Optional even-modulus rejection: MONT_REDUCE_ODD_CHECK_EN.
module mont_reduce
  import mont_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mont_reduce_if.slave  bus
);

  mont_state_e      state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] t_step;
  logic [WIDTH:0]   diff;
  logic             reject_c;

  mont_halve_step u_step (
    .t      (t_q),
    .N      (n_q),
    .t_next (t_step)
  );

  // Single shared subtractor; the borrow bit says t < N.
  assign diff = {1'b0, t_q} - {1'b0, n_q};

`ifdef MONT_REDUCE_ODD_CHECK_EN
  logic err_q, err_d;

  // An even modulus has no inverse of 2, so the request is bounced immediately.
  assign reject_c = ~bus.N[0];
  assign bus.err  = err_q;
`else
  assign reject_c = 1'b0;
  assign bus.err  = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    t_d      = t_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    finish_d = 1'b0;
    busy_d   = busy_q;
`ifdef MONT_REDUCE_ODD_CHECK_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (reject_c) begin
            m_d      = '0;
            finish_d = 1'b1;
`ifdef MONT_REDUCE_ODD_CHECK_EN
            err_d    = 1'b1;
`endif
          end else begin
            n_d     = bus.N;
            t_d     = bus.a;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = LOOP;
          end
        end
      end
      LOOP: begin
        t_d   = t_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST_ITER)) begin
          state_d = CORR;
        end
      end
      CORR: begin
        m_d      = diff[WIDTH] ? t_q : diff[WIDTH-1:0];
        finish_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      t_q      <= '0;
      cnt_q    <= '0;
      m_q      <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MONT_REDUCE_ODD_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      t_q      <= t_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
`ifdef MONT_REDUCE_ODD_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.m      = m_q;
  assign bus.finish = finish_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mont_reduce.sv
// Directed bench for mont_reduce; define MONT_REDUCE_ODD_CHECK_EN to cover rejection.
module tb_mont_reduce;
  import mont_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mont_reduce_if bus ();

  mont_reduce dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0]   nbig, nr, yr, ar;
  logic [2*WIDTH-1:0] wide;
  int                 lat, fins, last, seen;
  logic               bsy;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs after the accept edge, and wait for finish.
  task automatic run_op(input logic [WIDTH-1:0] n_in, input logic [WIDTH-1:0] a_in,
                        output int lat_o, output logic busy_acc);
    bus.start = 1'b1;
    bus.N     = n_in;
    bus.a     = a_in;
    step();
    busy_acc  = bus.busy;
    bus.start = 1'b0;
    bus.N     = ~n_in;
    bus.a     = ~a_in;
    lat_o     = -1;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (bus.finish) begin
        lat_o = c;
        break;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.N     = '0;
    bus.a     = '0;
    step();
    step();
    chk("rst_m", bus.m, '0);
    chk("rst_finish", WIDTH'(bus.finish), '0);
    chk("rst_busy", WIDTH'(bus.busy), '0);
    chk("rst_err", WIDTH'(bus.err), '0);
    rst = 1'b0;
    step();

    // N=3, a=1: 2^256 == 1 mod 3, so m = 1
    run_op(256'd3, 256'd1, lat, bsy);
    chk("n3a1_busy_acc", WIDTH'(bsy), WIDTH'(1));
    chk("n3a1_lat", WIDTH'(lat), WIDTH'(257));
    chk("n3a1_m", bus.m, 256'd1);
    chk("n3a1_err", WIDTH'(bus.err), '0);
    chk("n3a1_busy_fin", WIDTH'(bus.busy), '0);
    step();
    chk("n3a1_finish_1cyc", WIDTH'(bus.finish), '0);
    chk("n3a1_m_hold", bus.m, 256'd1);

    // N = 2^256-189 makes 2^256 == 189, so a = 189 maps back to 1
    nbig = '1;
    nbig = nbig - 256'd188;
    run_op(nbig, 256'd189, lat, bsy);
    chk("big_lat", WIDTH'(lat), WIDTH'(257));
    chk("big_m", bus.m, 256'd1);

    run_op(256'd3, 256'd0, lat, bsy);
    chk("n3a0_m", bus.m, 256'd0);
    run_op(256'd3, 256'd2, lat, bsy);
    chk("n3a2_m", bus.m, 256'd2);

    // N=7: 2^-256 == 4, so a=3 -> 5; back-to-back N=11: 2^-256 == 5
    run_op(256'd7, 256'd3, lat, bsy);
    chk("n7a3_m", bus.m, 256'd5);
    run_op(256'd11, 256'd1, lat, bsy);
    chk("b2b_lat", WIDTH'(lat), WIDTH'(257));
    chk("n11a1_m", bus.m, 256'd5);
    run_op(256'd7, 256'd6, lat, bsy);
    chk("n7a6_m", bus.m, 256'd3);

    // a == N sits exactly on the conditional subtract: result 0
    run_op(256'd7, 256'd7, lat, bsy);
    chk("n7a7_m", bus.m, 256'd0);

    // Round trip through the Montgomery mapping with random odd N
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 8; w++) nr[w*32 +: 32] = $urandom;
      nr[WIDTH-1] = 1'b1;
      nr[0]       = 1'b1;
      for (int w = 0; w < 8; w++) yr[w*32 +: 32] = $urandom;
      yr   = yr % nr;
      wide = {yr, {WIDTH{1'b0}}} % {{WIDTH{1'b0}}, nr};
      ar   = wide[WIDTH-1:0];
      run_op(nr, ar, lat, bsy);
      chk("rt_lat", WIDTH'(lat), WIDTH'(257));
      chk("rt_m", bus.m, yr);
    end
    step();

    // A start pulse while busy is dropped
    bus.start = 1'b1;
    bus.N     = 256'd11;
    bus.a     = 256'd1;
    step();
    bus.start = 1'b0;
    repeat (50) step();
    bus.start = 1'b1;
    bus.N     = 256'd3;
    bus.a     = 256'd2;
    step();
    bus.start = 1'b0;
    lat = -1;
    for (int c = 52; c <= 400; c++) begin
      step();
      if (bus.finish) begin
        lat = c;
        break;
      end
    end
    chk("ign_lat", WIDTH'(lat), WIDTH'(257));
    chk("ign_m", bus.m, 256'd5);
    repeat (3) step();
    chk("ign_no_queue", WIDTH'(bus.busy), '0);

    // start held high: accepted again in each finish cycle
    bus.start = 1'b1;
    bus.N     = 256'd7;
    bus.a     = 256'd3;
    fins = 0;
    last = -1;
    for (int c = 1; c <= 1000; c++) begin
      step();
      if (bus.finish) begin
        fins++;
        if (last >= 0) chk("hold_period", WIDTH'(c - last), WIDTH'(258));
        chk("hold_m", bus.m, 256'd5);
        last = c;
      end
    end
    chk("hold_count", WIDTH'(fins), WIDTH'(3));
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (bus.finish) begin
        seen = 1;
        break;
      end
    end
    chk("hold_drain", WIDTH'(seen), WIDTH'(1));
    step();

    // Reset at LOOP count 100 aborts without a finish
    bus.start = 1'b1;
    bus.N     = 256'd3;
    bus.a     = 256'd1;
    step();
    bus.start = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", WIDTH'(bus.busy), '0);
    chk("abort_m", bus.m, '0);
    chk("abort_finish", WIDTH'(bus.finish), '0);
    fins = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (bus.finish) fins++;
    end
    chk("abort_no_finish", WIDTH'(fins), '0);
    run_op(256'd11, 256'd1, lat, bsy);
    chk("post_abort_lat", WIDTH'(lat), WIDTH'(257));
    chk("post_abort_m", bus.m, 256'd5);
    step();

`ifdef MONT_REDUCE_ODD_CHECK_EN
    // Even modulus bounced on the accept edge
    bus.start = 1'b1;
    bus.N     = 256'd4;
    bus.a     = 256'd1;
    step();
    bus.start = 1'b0;
    chk("even_finish", WIDTH'(bus.finish), WIDTH'(1));
    chk("even_err", WIDTH'(bus.err), WIDTH'(1));
    chk("even_m", bus.m, '0);
    chk("even_busy", WIDTH'(bus.busy), '0);
    step();
    chk("even_finish_1cyc", WIDTH'(bus.finish), '0);
    chk("even_err_1cyc", WIDTH'(bus.err), '0);
    chk("even_busy_after", WIDTH'(bus.busy), '0);
`else
    // Even modulus runs the full loop with err held low
    run_op(256'd4, 256'd1, lat, bsy);
    chk("even_lat", WIDTH'(lat), WIDTH'(257));
    chk("even_err", WIDTH'(bus.err), '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mont_reduce.md
MONT_REDUCE -- requirements
Module: mont_reduce

Interface
REQ-001 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 Port rst, input, 1, reset; synchronous, active-high.
REQ-003 Port start, input, 1, request pulse, sampled only in IDLE.
REQ-004 Port N, input, 256, modulus; odd and nonzero for valid operation.
REQ-005 Port a, input, 256, Montgomery-domain operand; a < N required.
REQ-006 Port m, output, 256, registered result a*2^-256 mod N; holds value until the next finish.
REQ-007 Port finish, output, 1, registered one-cycle pulse marking m valid.
REQ-008 Port busy, output, 1, registered; high from the accept edge until the finish edge.
REQ-009 Port err, output, 1, registered; pulses with finish on a rejected request, otherwise 0.

Function
REQ-010 The block SHALL compute m = a*2^-256 mod N, the inverse of the y*2^256 mod N pre-mapping.
REQ-011 FSM states SHALL be IDLE, LOOP, CORR.
REQ-012 In IDLE with start=1, the block SHALL latch N and a, set t=a, count=0, busy=1, and enter LOOP.
REQ-013 Each LOOP cycle SHALL set t = (t + (t[0] ? N : 0)) >> 1 using a 257-bit sum, and increment count.
REQ-014 After 256 LOOP iterations (count==255 at the edge), the FSM SHALL enter CORR.
REQ-015 CORR SHALL set m = (t >= N) ? t - N : t (one conditional subtract), finish=1, busy=0, and return to IDLE.
REQ-016 Latency: if start is sampled at edge E, finish SHALL be high during the cycle after edge E+257.
REQ-017 finish SHALL last exactly one cycle; err SHALL be 0 on every normal completion.
REQ-018 A start asserted while busy SHALL be ignored, with no queuing.
REQ-019 A start sampled in the cycle in which finish is high SHALL be accepted, giving a back-to-back period of 258 cycles.
REQ-020 Input changes on N or a after the accept edge SHALL NOT affect the running result.
REQ-021 Intermediate t SHALL never exceed 257 bits, and the result SHALL satisfy m < N whenever a < N.

Reset
REQ-022 With rst=1 at an edge: state=IDLE, count=0, t=0, m=0, finish=0, busy=0, err=0.
REQ-023 Reset SHALL take priority over start and over any in-flight operation.
REQ-024 A reset applied mid-LOOP SHALL abort the operation, with no finish pulse produced.

Configuration
REQ-025 Macro MONT_REDUCE_ODD_CHECK_EN SHALL control even-modulus rejection.
REQ-026 With the macro defined, an accepted start with N[0]==0 SHALL skip LOOP and pulse finish=1 and err=1 at the next edge, with m=0 and busy low throughout.
REQ-027 Without the macro, err SHALL be tied to 0 and even N SHALL run normally, with an undefined result.

Structure
REQ-028 Shared package mont_pkg SHALL hold the WIDTH=256 constant, the 9-bit count width, and the FSM state enum typedef.
REQ-029 One combinational sub-module, mont_halve_step, SHALL implement the REQ-013 iteration (t, N in; t_next out).
REQ-030 Each arithmetic step SHALL use a single shared adder or subtractor.

Verification
REQ-031 Scenario: N=3, a=1, start pulse -> finish during the cycle after edge E+257; m=1, err=0.
REQ-032 Scenario: N=2^256-189, a=189 -> m=1.
REQ-033 Scenario: N=3, a=0, then N=3, a=2 -> m=0, then m=2.
REQ-034 Scenario: round trip with random odd N and y<N, feed y*2^256 mod N as a -> m=y.
REQ-035 Scenario: rst=1 at LOOP count 100 -> busy=0, m=0, no finish; a subsequent start gives the correct result.
REQ-036 Scenario: start held high for 1000 cycles -> finish pulses 258 cycles apart; with MONT_REDUCE_ODD_CHECK_EN, N=4 -> finish=1 and err=1 one cycle after accept, m=0.
